rgb_pwm_driver: RTL and testbench
=================================

# rgb_pwm_driver

Consumes the 24-bit RGB `light` word produced by the lights selector and drives three physical LED pins with pulse-width-modulated outputs. Each 8-bit colour channel sets the duty cycle of its pin. Duty values are sampled only at period boundaries, so a colour change never glitches a period already in progress. The block sits between the selector and the top-level LED pins, in the same clock domain.

## Interface
Parameters:
- `PRESCALE`, default 4: clock cycles per PWM step, legal range ≥1.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable; low forces the outputs off and holds the counters in their initial state.
- `light`  in  24  colour word: R=[23:16], G=[15:8], B=[7:0].
- `led_r`, `led_g`, `led_b`  out  1 each  PWM outputs, registered.
- `frame_start`  out  1  registered one-cycle pulse marking the first cycle of each PWM period on the LED outputs.

## Operation
- Prescaler `pre` counts 0..PRESCALE-1. A step `tick` occurs in the cycle where `pre`==PRESCALE-1.
- Step counter `cnt` counts 0..254 and advances only on `tick`. It wraps from 254 to 0, giving a period of 255 steps (255·PRESCALE cycles).
- Boundary condition: `en`=1 and `pre`=0 and `cnt`=0.
  - At a boundary, `shadow` is loaded with `light`.
  - The effective duty for that cycle is `light`; otherwise it is `shadow`.
- Every cycle with `en`=1, each LED register is loaded with the comparison (`cnt` < effective duty of its channel), unsigned 8-bit.
  - Duty 0x00 gives always off.
  - Duty 0xFF gives always on, since `cnt` never reaches 255.
  - Duty d gives a high time of d·PRESCALE cycles per period, starting at the period's first cycle.
- `frame_start` is registered high in the cycle after a boundary and low otherwise.
- With `en`=0:
  - `pre` and `cnt` are cleared to 0.
  - All LED outputs and `frame_start` are registered to 0.
  - `shadow` holds its value.
- Changes to `light` in mid-period are ignored until the next boundary.
- With PRESCALE=1, `pre` stays at 0 and `tick` is asserted every cycle.

## Timing
- Reset (`rst`=0) asynchronously clears `pre`, `cnt`, `shadow`, `led_r`, `led_g`, `led_b` and `frame_start` to 0. No clock edge is needed.
- Reset may be asserted mid-period. The outputs go to 0 immediately, and the first boundary after release is the first cycle in which `en`=1.
- Latency from `light` to the LEDs:
  - The LEDs reflect a new colour in the cycle after the next boundary.
  - Worst case is 255·PRESCALE+1 cycles.
  - When `en` rises, the latency is exactly 1 cycle.
- Behaviour when `en` rises:
  - The first cycle with `en`=1 is a boundary.
  - `frame_start` and the first-step LED levels appear one cycle later.
- Behaviour when `en` falls: the LEDs and `frame_start` are 0 in the cycle after the first cycle with `en`=0.
- `frame_start` pulses exactly once per period, every 255·PRESCALE cycles, while `en` is held high.

## Structure
- Shared package `light_pkg` holds:
  - the channel slice constants (R_MSB=23, R_LSB=16, G_MSB=15, G_LSB=8, B_MSB=7, B_LSB=0);
  - `PWM_STEPS`=255;
  - the 8-bit duty typedef.
  The lights selector reuses these.
- Sub-module `pwm_channel`, instantiated three times. It contains:
  - one 8-bit shadow register;
  - the boundary-load mux;
  - the registered compare.
  It takes `cnt`, `boundary`, `en` and the duty slice.
- The prescaler, step counter and `frame_start` live in the top level.

## Test plan
- Reset:
  - Stimulus: `rst`=0 with random `light` and `en`=1; then release with `en`=0 for 20 cycles.
  - Response: all outputs are 0 throughout, including immediately on the asynchronous assert between clock edges.
- Full red:
  - Stimulus: `light`=24'hFF0000, PRESCALE=4, `en`=1.
  - Response: `led_r` is high every cycle from 1 cycle after `en`; `led_g` and `led_b` stay 0; `frame_start` pulses every 1020 cycles.
- Duty accuracy:
  - Stimulus: `light`=24'h804001.
  - Response: starting at the `frame_start` cycle, `led_r` is high for 512 cycles, `led_g` for 256 and `led_b` for 4, and each is low for the rest of the 1020-cycle period.
- Mid-period change:
  - Stimulus: `light` switches from 24'h00FF00 to 24'h0000FF at cycle 300 of a period.
  - Response: `led_g` stays high and `led_b` stays low until the next `frame_start`; from then on, only `led_b` is high.
- Enable toggle:
  - Stimulus: drop `en` at cycle 100 of a period, then raise it again 10 cycles later.
  - Response: the LEDs are 0 one cycle after the drop; `frame_start` pulses 1 cycle after the raise, and the new period uses the current `light`.
- PRESCALE=1:
  - Stimulus: `light`=24'h010203.
  - Response: `frame_start` pulses every 255 cycles; `led_r`, `led_g` and `led_b` are high for 1, 2 and 3 cycles respectively per period.

Source files
------------

// File: rtl/light_pkg.sv
// Shared definitions for the lights datapath: colour-word slicing,
// PWM period length and the per-channel duty type.
package light_pkg;
    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    // Step counter runs 0..PWM_STEPS-1, so duty 0xFF is never reached
    // by the counter and means always on.
    localparam int PWM_STEPS = 255;

    typedef logic [7:0] duty_t;
endpackage

// File: rtl/rgb_pwm_driver_channel.sv
// One PWM channel: shadowed duty captured at period boundaries and a
// registered compare against the shared step counter.
module pwm_channel
    import light_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  boundary,
    input  duty_t cnt,
    input  duty_t duty,
    output logic  led
);

    duty_t shadow;
    duty_t eff_duty;

    // At a boundary the incoming duty takes effect in the same cycle it is captured.
    always_comb begin
        eff_duty = shadow;
        if (boundary) begin
            eff_duty = duty;
        end
    end

    // Shadow only updates at boundaries so a period in progress never glitches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= '0;
        end else if (boundary) begin
            shadow <= duty;
        end
    end

    // Registered compare; forced off while disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led <= 1'b0;
        end else if (en) begin
            led <= (cnt < eff_duty);
        end else begin
            led <= 1'b0;
        end
    end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM LED driver. Prescaler and step counter are shared;
// each colour channel owns its shadow register and compare.
module rgb_pwm_driver
    import light_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] light,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b,
    output logic        frame_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre;
    duty_t         cnt;
    logic          tick;
    logic          boundary;

    // Step strobe and period-start detection.
    always_comb begin
        tick     = (pre == PW'(PRESCALE - 1));
        boundary = en && (pre == '0) && (cnt == '0);
    end

    // Prescaler and step counter; held cleared while disabled so that
    // the first enabled cycle is always a boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre <= '0;
            cnt <= '0;
        end else if (!en) begin
            pre <= '0;
            cnt <= '0;
        end else if (tick) begin
            pre <= '0;
            cnt <= (cnt == duty_t'(PWM_STEPS - 1)) ? '0 : cnt + 8'd1;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // Frame marker lines up with the first LED level of each period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= boundary;
        end
    end

    pwm_channel u_ch_r (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .boundary (boundary),
        .cnt      (cnt),
        .duty     (light[R_MSB:R_LSB]),
        .led      (led_r)
    );

    pwm_channel u_ch_g (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .boundary (boundary),
        .cnt      (cnt),
        .duty     (light[G_MSB:G_LSB]),
        .led      (led_g)
    );

    pwm_channel u_ch_b (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .boundary (boundary),
        .cnt      (cnt),
        .duty     (light[B_MSB:B_LSB]),
        .led      (led_b)
    );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: one instance at PRESCALE=4 and one
// at PRESCALE=1 share the inputs; outputs are sampled 1 time unit after
// each rising edge, and inputs are changed at the same point.
module tb_rgb_pwm_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [23:0] light;
    logic        led_r, led_g, led_b, frame_start;
    logic        led_r1, led_g1, led_b1, frame_start1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rgb_pwm_driver #(.PRESCALE(4)) dut (
        .clk (clk), .rst (rst), .en (en), .light (light),
        .led_r (led_r), .led_g (led_g), .led_b (led_b),
        .frame_start (frame_start)
    );

    rgb_pwm_driver #(.PRESCALE(1)) dut1 (
        .clk (clk), .rst (rst), .en (en), .light (light),
        .led_r (led_r1), .led_g (led_g1), .led_b (led_b1),
        .frame_start (frame_start1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] all_out();
        return {led_r, led_g, led_b, frame_start, led_r1, led_g1, led_b1, frame_start1};
    endfunction

    // Drop en for two cycles, then raise it with the given colour. The next
    // sample taken by the caller is the first cycle of a period.
    task automatic restart(input logic [23:0] col);
        en = 1'b0;
        cyc();
        cyc();
        light = col;
        en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, bad_r, bad_g, bad_b, fs_n, fs_bad;

        // Reset held with random colour and en high.
        rst = 1'b0;
        en = 1'b1;
        light = 24'($urandom);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (all_out() != 8'h00) bad++;
        end
        chk("reset_hold", bad, 0);

        // Release reset: first enabled cycle is a boundary.
        light = 24'hFFFFFF;
        rst = 1'b1;
        cyc();
        chk("post_reset_fs", all_out(), 8'hFF);
        for (int i = 0; i < 30; i++) cyc();
        chk("running_all_on", {led_r, led_g, led_b}, 3'b111);

        // Asynchronous assert between edges.
        #3 rst = 1'b0;
        #1;
        chk("async_reset", all_out(), 8'h00);
        cyc();
        cyc();
        en = 1'b0;
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (all_out() != 8'h00) bad++;
        end
        chk("reset_release_en0", bad, 0);

        // Full red at PRESCALE=4.
        light = 24'hFF0000;
        en = 1'b1;
        bad_r = 0; bad = 0; fs_n = 0; fs_bad = 0;
        for (int i = 0; i <= 2040; i++) begin
            cyc();
            if (led_r !== 1'b1) bad_r++;
            if (led_g !== 1'b0 || led_b !== 1'b0) bad++;
            if (frame_start === 1'b1) begin
                fs_n++;
                if (i % 1020 != 0) fs_bad++;
            end
        end
        chk("red_led_r", bad_r, 0);
        chk("red_led_gb", bad, 0);
        chk("red_fs_count", fs_n, 3);
        chk("red_fs_spacing", fs_bad, 0);

        // Duty accuracy with 0x80/0x40/0x01.
        restart(24'h804001);
        bad_r = 0; bad_g = 0; bad_b = 0; fs_n = 0;
        for (int i = 0; i < 1020; i++) begin
            cyc();
            if (led_r !== (i < 512)) bad_r++;
            if (led_g !== (i < 256)) bad_g++;
            if (led_b !== (i < 4)) bad_b++;
            if (frame_start === 1'b1) fs_n += (i == 0) ? 1 : 100;
        end
        chk("duty_r", bad_r, 0);
        chk("duty_g", bad_g, 0);
        chk("duty_b", bad_b, 0);
        chk("duty_fs", fs_n, 1);

        // Mid-period colour change is deferred to the next period.
        restart(24'h00FF00);
        bad = 0; bad_b = 0;
        for (int i = 0; i < 2040; i++) begin
            cyc();
            if (i < 1020) begin
                if ({led_r, led_g, led_b} !== 3'b010) bad++;
            end else begin
                if ({led_r, led_g, led_b} !== 3'b001) bad_b++;
            end
            if (i == 1020) chk("mid_fs_next", frame_start, 1'b1);
            if (i == 300) light = 24'h0000FF;
        end
        chk("mid_old_colour", bad, 0);
        chk("mid_new_colour", bad_b, 0);

        // Enable toggle mid-period picks up the current colour on return.
        restart(24'hFF0000);
        for (int i = 0; i <= 100; i++) cyc();
        chk("toggle_before", led_r, 1'b1);
        en = 1'b0;
        light = 24'h0000FF;
        cyc();
        chk("toggle_drop", all_out(), 8'h00);
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            cyc();
            if (all_out() != 8'h00) bad++;
        end
        chk("toggle_off_hold", bad, 0);
        en = 1'b1;
        cyc();
        chk("toggle_raise", {led_r, led_g, led_b, frame_start}, 4'b0011);

        // PRESCALE=1 instance with 0x01/0x02/0x03.
        restart(24'h010203);
        bad_r = 0; bad_g = 0; bad_b = 0; fs_n = 0; fs_bad = 0;
        for (int i = 0; i < 510; i++) begin
            cyc();
            if (led_r1 !== ((i % 255) < 1)) bad_r++;
            if (led_g1 !== ((i % 255) < 2)) bad_g++;
            if (led_b1 !== ((i % 255) < 3)) bad_b++;
            if (frame_start1 === 1'b1) begin
                fs_n++;
                if (i % 255 != 0) fs_bad++;
            end
        end
        chk("p1_r", bad_r, 0);
        chk("p1_g", bad_g, 0);
        chk("p1_b", bad_b, 0);
        chk("p1_fs_count", fs_n, 2);
        chk("p1_fs_spacing", fs_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
